// File: rtl/rom_access_sequencer.sv
// Cart SRAM/PSRAM bus sequencer: SNES and MCU requests, SNES always wins the arbitration.
// A request becomes pending on its start edge; the strobes run for RD_WAIT/WR_WAIT cycles.
// Config macro MCU_ARBITRATION_EN: defined = MCU port active; undefined = MCU port tied off (RDY=1, DINr=0).
module rom_access_sequencer #(
    parameter int unsigned RD_WAIT = 4,
    parameter int unsigned WR_WAIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        snes_rd_start_i,
    input  logic        snes_wr_start_i,
    input  logic        rom_hit_i,
    input  logic        is_writable_i,
    input  logic [23:0] rom_addr_i,
    input  logic [7:0]  snes_data_in_i,
    output logic [7:0]  snes_data_out_o,
    input  logic        mcu_rrq_i,
    input  logic        mcu_wrq_i,
    input  logic [23:0] mcu_addr_i,
    input  logic [7:0]  mcu_dout_i,
    output logic [7:0]  mcu_dinr_o,
    output logic        mcu_rdy_o,
    output logic [23:0] mem_addr_o,
    output logic [7:0]  mem_dout_o,
    input  logic [7:0]  mem_din_i,
    output logic        mem_doe_o,
    output logic        mem_ce_n_o,
    output logic        mem_oe_n_o,
    output logic        mem_we_n_o
);

    localparam logic [3:0] RD_CNT = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_CNT = 4'(WR_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SRD,
        SWR
`ifdef MCU_ARBITRATION_EN
        ,
        MRD,
        MWR
`endif
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        srd_pend_q;
    logic        swr_pend_q;
    logic [23:0] srd_addr_q;
    logic [23:0] swr_addr_q;
    logic [7:0]  swr_dat_q;
    logic [23:0] mem_addr_q;
    logic [7:0]  mem_dout_q;
    logic        mem_doe_q;
    logic        mem_ce_n_q;
    logic        mem_oe_n_q;
    logic        mem_we_n_q;
    logic [7:0]  snes_data_q;

    // Qualified SNES starts; a write colliding with a read start is dropped.
    logic snes_rd_go_d;
    logic snes_wr_go_d;
    assign snes_rd_go_d = snes_rd_start_i & rom_hit_i;
    assign snes_wr_go_d = snes_wr_start_i & rom_hit_i & is_writable_i & ~snes_rd_start_i;

`ifdef MCU_ARBITRATION_EN
    logic        mrd_pend_q;
    logic        mwr_pend_q;
    logic [7:0]  mcu_wdat_q;
    logic [7:0]  mcu_dinr_q;
    logic        mcu_rdy_q;
    assign mcu_dinr_o = mcu_dinr_q;
    assign mcu_rdy_o  = mcu_rdy_q;
`else
    logic unused_mcu;
    assign unused_mcu = &{1'b0, mcu_rrq_i, mcu_wrq_i, mcu_addr_i, mcu_dout_i};
    assign mcu_dinr_o = 8'h00;
    assign mcu_rdy_o  = 1'b1;
`endif

    // Arbitration FSM, strobe generation and request capture in one registered block.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            srd_pend_q  <= 1'b0;
            swr_pend_q  <= 1'b0;
            srd_addr_q  <= 24'd0;
            swr_addr_q  <= 24'd0;
            swr_dat_q   <= 8'd0;
            mem_addr_q  <= 24'd0;
            mem_dout_q  <= 8'd0;
            mem_doe_q   <= 1'b0;
            mem_ce_n_q  <= 1'b1;
            mem_oe_n_q  <= 1'b1;
            mem_we_n_q  <= 1'b1;
            snes_data_q <= 8'd0;
`ifdef MCU_ARBITRATION_EN
            mrd_pend_q  <= 1'b0;
            mwr_pend_q  <= 1'b0;
            mcu_wdat_q  <= 8'd0;
            mcu_dinr_q  <= 8'd0;
            mcu_rdy_q   <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (srd_pend_q) begin
                        state_q    <= SRD;
                        cnt_q      <= RD_CNT;
                        srd_pend_q <= 1'b0;
                        mem_addr_q <= srd_addr_q;
                        mem_ce_n_q <= 1'b0;
                        mem_oe_n_q <= 1'b0;
                    end else if (swr_pend_q) begin
                        state_q    <= SWR;
                        cnt_q      <= WR_CNT;
                        swr_pend_q <= 1'b0;
                        mem_addr_q <= swr_addr_q;
                        mem_dout_q <= swr_dat_q;
                        mem_doe_q  <= 1'b1;
                        mem_ce_n_q <= 1'b0;
                        mem_we_n_q <= 1'b0;
                    end
`ifdef MCU_ARBITRATION_EN
                    else if (mrd_pend_q) begin
                        state_q    <= MRD;
                        cnt_q      <= RD_CNT;
                        mrd_pend_q <= 1'b0;
                        mem_addr_q <= mcu_addr_i;
                        mem_ce_n_q <= 1'b0;
                        mem_oe_n_q <= 1'b0;
                    end else if (mwr_pend_q) begin
                        state_q    <= MWR;
                        cnt_q      <= WR_CNT;
                        mwr_pend_q <= 1'b0;
                        mem_addr_q <= mcu_addr_i;
                        mem_dout_q <= mcu_wdat_q;
                        mem_doe_q  <= 1'b1;
                        mem_ce_n_q <= 1'b0;
                        mem_we_n_q <= 1'b0;
                    end
`endif
                end
                SRD: begin
                    if (cnt_q == 4'd0) begin
                        snes_data_q <= mem_din_i;
                        mem_ce_n_q  <= 1'b1;
                        mem_oe_n_q  <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                SWR: begin
                    if (cnt_q == 4'd0) begin
                        mem_ce_n_q <= 1'b1;
                        mem_we_n_q <= 1'b1;
                        mem_doe_q  <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
`ifdef MCU_ARBITRATION_EN
                MRD: begin
                    if (cnt_q == 4'd0) begin
                        mcu_dinr_q <= mem_din_i;
                        mcu_rdy_q  <= 1'b1;
                        mem_ce_n_q <= 1'b1;
                        mem_oe_n_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                MWR: begin
                    if (cnt_q == 4'd0) begin
                        mcu_rdy_q  <= 1'b1;
                        mem_ce_n_q <= 1'b1;
                        mem_we_n_q <= 1'b1;
                        mem_doe_q  <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase

            // New starts come after the case so a fresh request beats the clear of a served one.
            if (snes_rd_go_d) begin
                srd_pend_q <= 1'b1;
                srd_addr_q <= rom_addr_i;
            end
            if (snes_wr_go_d) begin
                swr_pend_q <= 1'b1;
                swr_addr_q <= rom_addr_i;
                swr_dat_q  <= snes_data_in_i;
            end
`ifdef MCU_ARBITRATION_EN
            // MCU requests only accepted while the port is idle; a read wins a same-edge write.
            if (mcu_rdy_q) begin
                if (mcu_rrq_i) begin
                    mrd_pend_q <= 1'b1;
                    mcu_rdy_q  <= 1'b0;
                end else if (mcu_wrq_i) begin
                    mwr_pend_q <= 1'b1;
                    mcu_wdat_q <= mcu_dout_i;
                    mcu_rdy_q  <= 1'b0;
                end
            end
`endif
        end
    end

    assign snes_data_out_o = snes_data_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_dout_o      = mem_dout_q;
    assign mem_doe_o       = mem_doe_q;
    assign mem_ce_n_o      = mem_ce_n_q;
    assign mem_oe_n_o      = mem_oe_n_q;
    assign mem_we_n_o      = mem_we_n_q;

endmodule

// File: tb/tb_rom_access_sequencer.sv
// Directed bench for rom_access_sequencer with RD_WAIT = WR_WAIT = 4.
// Outputs are sampled 1 time unit after each rising edge.
// MCU scenarios run only when MCU_ARBITRATION_EN is defined; otherwise the tie-off is checked.
module tb_rom_access_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snes_rd_start = 1'b0;
    logic        snes_wr_start = 1'b0;
    logic        rom_hit = 1'b0;
    logic        is_writable = 1'b0;
    logic [23:0] rom_addr = 24'd0;
    logic [7:0]  snes_data_in = 8'd0;
    logic [7:0]  snes_data_out;
    logic        mcu_rrq = 1'b0;
    logic        mcu_wrq = 1'b0;
    logic [23:0] mcu_addr = 24'd0;
    logic [7:0]  mcu_dout = 8'd0;
    logic [7:0]  mcu_dinr;
    logic        mcu_rdy;
    logic [23:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = 8'd0;
    logic        mem_doe;
    logic        mem_ce_n;
    logic        mem_oe_n;
    logic        mem_we_n;

    int checks = 0;
    int errors = 0;

    rom_access_sequencer #(.RD_WAIT(4), .WR_WAIT(4)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .snes_rd_start_i (snes_rd_start),
        .snes_wr_start_i (snes_wr_start),
        .rom_hit_i       (rom_hit),
        .is_writable_i   (is_writable),
        .rom_addr_i      (rom_addr),
        .snes_data_in_i  (snes_data_in),
        .snes_data_out_o (snes_data_out),
        .mcu_rrq_i       (mcu_rrq),
        .mcu_wrq_i       (mcu_wrq),
        .mcu_addr_i      (mcu_addr),
        .mcu_dout_i      (mcu_dout),
        .mcu_dinr_o      (mcu_dinr),
        .mcu_rdy_o       (mcu_rdy),
        .mem_addr_o      (mem_addr),
        .mem_dout_o      (mem_dout),
        .mem_din_i       (mem_din),
        .mem_doe_o       (mem_doe),
        .mem_ce_n_o      (mem_ce_n),
        .mem_oe_n_o      (mem_oe_n),
        .mem_we_n_o      (mem_we_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_ce_n", 32'(mem_ce_n), 32'd1);
        chk("rst_oe_n", 32'(mem_oe_n), 32'd1);
        chk("rst_we_n", 32'(mem_we_n), 32'd1);
        chk("rst_doe", 32'(mem_doe), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_dout", 32'(mem_dout), 32'd0);
        chk("rst_sdo", 32'(snes_data_out), 32'd0);
        chk("rst_rdy", 32'(mcu_rdy), 32'd1);
        chk("rst_dinr", 32'(mcu_dinr), 32'd0);
        rst_n = 1'b1;
        tick();

        // SNES read: start sampled at edge 0, strobes edges 1..4, data at edge 5
        rom_hit = 1'b1;
        rom_addr = 24'h123456;
        snes_rd_start = 1'b1;
        tick();
        snes_rd_start = 1'b0;
        chk("rd_e0_ce_n", 32'(mem_ce_n), 32'd1);
        mem_din = 8'hA5;
        tick();
        chk("rd_e1_addr", 32'(mem_addr), 32'h123456);
        chk("rd_e1_ce_n", 32'(mem_ce_n), 32'd0);
        chk("rd_e1_oe_n", 32'(mem_oe_n), 32'd0);
        chk("rd_e1_we_n", 32'(mem_we_n), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("rd_hold_ce_oe", 32'({mem_ce_n, mem_oe_n}), 32'd0);
        end
        tick();
        chk("rd_e5_ce_n", 32'(mem_ce_n), 32'd1);
        chk("rd_e5_oe_n", 32'(mem_oe_n), 32'd1);
        chk("rd_e5_sdo", 32'(snes_data_out), 32'hA5);

        // Write to a non-writable address: dropped, nothing toggles
        is_writable = 1'b0;
        snes_data_in = 8'h77;
        snes_wr_start = 1'b1;
        tick();
        snes_wr_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("wr_nw_strobes", 32'({mem_ce_n, mem_we_n, mem_doe}), 32'b110);
        end

        // Unqualified read (no ROM hit): dropped, read data holds
        rom_hit = 1'b0;
        snes_rd_start = 1'b1;
        tick();
        snes_rd_start = 1'b0;
        tick();
        tick();
        chk("rd_miss_ce_n", 32'(mem_ce_n), 32'd1);
        chk("rd_miss_sdo", 32'(snes_data_out), 32'hA5);

        // Writable SNES write
        rom_hit = 1'b1;
        is_writable = 1'b1;
        rom_addr = 24'h00ABCD;
        snes_data_in = 8'h3C;
        snes_wr_start = 1'b1;
        tick();
        snes_wr_start = 1'b0;
        snes_data_in = 8'h00;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("wr_we_n", 32'(mem_we_n), 32'd0);
            chk("wr_ce_n", 32'(mem_ce_n), 32'd0);
            chk("wr_oe_n", 32'(mem_oe_n), 32'd1);
            chk("wr_doe", 32'(mem_doe), 32'd1);
            chk("wr_dout", 32'(mem_dout), 32'h3C);
            chk("wr_addr", 32'(mem_addr), 32'h00ABCD);
        end
        tick();
        chk("wr_end_strobes", 32'({mem_ce_n, mem_we_n, mem_doe}), 32'b110);

        // Read and write start on the same edge: read taken, write dropped
        rom_addr = 24'h000777;
        snes_data_in = 8'hEE;
        snes_rd_start = 1'b1;
        snes_wr_start = 1'b1;
        tick();
        snes_rd_start = 1'b0;
        snes_wr_start = 1'b0;
        mem_din = 8'h5A;
        tick();
        chk("col_oe_n", 32'(mem_oe_n), 32'd0);
        chk("col_we_n", 32'(mem_we_n), 32'd1);
        tick();
        tick();
        tick();
        tick();
        chk("col_sdo", 32'(snes_data_out), 32'h5A);
        tick();
        chk("col_no_wr", 32'({mem_ce_n, mem_we_n, mem_doe}), 32'b110);

`ifdef MCU_ARBITRATION_EN
        // MCU read, SNES read arrives two edges later and waits
        mcu_addr = 24'hE00010;
        mcu_rrq = 1'b1;
        tick();
        mcu_rrq = 1'b0;
        mem_din = 8'hC3;
        tick();
        chk("m3_e1_addr", 32'(mem_addr), 32'hE00010);
        chk("m3_e1_oe", 32'({mem_ce_n, mem_oe_n}), 32'd0);
        chk("m3_e1_rdy", 32'(mcu_rdy), 32'd0);
        rom_addr = 24'h010203;
        snes_rd_start = 1'b1;
        tick();
        snes_rd_start = 1'b0;
        tick();
        tick();
        chk("m3_e4_addr", 32'(mem_addr), 32'hE00010);
        chk("m3_e4_rdy", 32'(mcu_rdy), 32'd0);
        tick();
        chk("m3_e5_rdy", 32'(mcu_rdy), 32'd1);
        chk("m3_e5_dinr", 32'(mcu_dinr), 32'hC3);
        chk("m3_e5_ce_n", 32'(mem_ce_n), 32'd1);
        tick();
        chk("m3_e6_addr", 32'(mem_addr), 32'h010203);
        chk("m3_e6_oe", 32'({mem_ce_n, mem_oe_n}), 32'd0);
        mem_din = 8'h66;
        for (int i = 7; i <= 10; i++) tick();
        chk("m3_e10_sdo", 32'(snes_data_out), 32'h66);
        chk("m3_e10_dinr", 32'(mcu_dinr), 32'hC3);

        // SNES read and MCU write on the same edge
        rom_addr = 24'h000100;
        mcu_addr = 24'h000200;
        mcu_dout = 8'h99;
        snes_rd_start = 1'b1;
        mcu_wrq = 1'b1;
        tick();
        snes_rd_start = 1'b0;
        mcu_wrq = 1'b0;
        mcu_dout = 8'h00;
        mem_din = 8'h11;
        tick();
        chk("m4_e1_addr", 32'(mem_addr), 32'h000100);
        chk("m4_e1_rdy", 32'(mcu_rdy), 32'd0);
        for (int i = 2; i <= 5; i++) tick();
        chk("m4_e5_sdo", 32'(snes_data_out), 32'h11);
        chk("m4_e5_rdy", 32'(mcu_rdy), 32'd0);
        tick();
        chk("m4_e6_we", 32'({mem_ce_n, mem_we_n, mem_doe}), 32'b001);
        chk("m4_e6_dout", 32'(mem_dout), 32'h99);
        chk("m4_e6_addr", 32'(mem_addr), 32'h000200);
        chk("m4_e6_rdy", 32'(mcu_rdy), 32'd0);
        for (int i = 7; i <= 9; i++) tick();
        chk("m4_e9_rdy", 32'(mcu_rdy), 32'd0);
        tick();
        chk("m4_e10_rdy", 32'(mcu_rdy), 32'd1);
        chk("m4_e10_we", 32'({mem_ce_n, mem_we_n, mem_doe}), 32'b110);
`else
        // MCU port tied off: requests ignored
        mcu_addr = 24'hE00010;
        mcu_rrq = 1'b1;
        tick();
        mcu_rrq = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("nomcu_ce_n", 32'(mem_ce_n), 32'd1);
            chk("nomcu_rdy", 32'(mcu_rdy), 32'd1);
        end
        chk("nomcu_dinr", 32'(mcu_dinr), 32'd0);
`endif

        // Reset during SRD with cnt=2: strobes high next edge, read abandoned
        rom_addr = 24'h0F0F0F;
        snes_rd_start = 1'b1;
        tick();
        snes_rd_start = 1'b0;
        tick();
        tick();
        chk("rst_mid_ce_n_pre", 32'(mem_ce_n), 32'd0);
        rst_n = 1'b0;
        mem_din = 8'hFF;
        tick();
        chk("rst_mid_ce_n", 32'(mem_ce_n), 32'd1);
        chk("rst_mid_oe_n", 32'(mem_oe_n), 32'd1);
        chk("rst_mid_sdo", 32'(snes_data_out), 32'd0);
        chk("rst_mid_rdy", 32'(mcu_rdy), 32'd1);
        chk("rst_mid_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_mid_idle", 32'({mem_ce_n, mem_oe_n}), 32'b11);
        end
        chk("rst_mid_sdo_hold", 32'(snes_data_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
